// File: rtl/wb_arbiter.sv
// wb_arbiter: merges a single-cycle A result stream and a buffered B result stream onto one register-file write port
module wb_arbiter #(
  parameter int FIFO_DEPTH = 4,
  parameter int STARVE_MAX = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        a_valid,
  input  logic [4:0]  a_rd,
  input  logic [31:0] a_data,
  output logic        a_ready,
  input  logic        b_valid,
  input  logic [4:0]  b_rd,
  input  logic [31:0] b_data,
  output logic        b_ready,
  output logic        we,
  output logic [4:0]  rwaddr,
  output logic [31:0] din,
  output logic [31:0] pend_mask
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = $clog2(STARVE_MAX + 2);
  logic [4:0]    r_rd   [FIFO_DEPTH];
  logic [31:0]   r_data [FIFO_DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [CW-1:0] r_cnt;
  logic [SW-1:0] r_starve;
  logic          w_empty, w_force, w_push, w_take_a, w_pop, w_sel;
  logic [4:0]    w_sel_rd;
  logic [31:0]   w_sel_data;
  logic [AW-1:0] w_off;
  assign w_empty    = r_cnt == '0;
  assign w_force    = (r_starve == SW'(STARVE_MAX)) && !w_empty;
  assign a_ready    = !w_force;
  assign b_ready    = r_cnt < CW'(FIFO_DEPTH);
  assign w_push     = b_valid && b_ready;
  assign w_take_a   = a_valid && !w_force;
  assign w_pop      = !w_empty && !w_take_a;
  assign w_sel      = w_take_a || w_pop;
  assign w_sel_rd   = w_take_a ? a_rd : r_rd[r_rp];
  assign w_sel_data = w_take_a ? a_data : r_data[r_rp];
  // FIFO pointers, occupancy and the B starvation counter
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wp     <= '0;
      r_rp     <= '0;
      r_cnt    <= '0;
      r_starve <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + AW'(1);
      if (w_pop) r_rp <= r_rp + AW'(1);
      r_cnt    <= r_cnt + CW'(w_push) - CW'(w_pop);
      r_starve <= (w_empty || w_pop) ? '0 :
                  (w_take_a && r_starve != SW'(STARVE_MAX)) ? r_starve + SW'(1) : r_starve;
    end
  end
  // FIFO storage; stale slots are masked by the occupancy count so no reset is needed
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_rd[r_wp]   <= b_rd;
      r_data[r_wp] <= b_data;
    end
  end
  // registered write port; x0 targets and idle cycles keep the previous address/data
  always_ff @(posedge clk) begin
    if (rst) begin
      we     <= 1'b0;
      rwaddr <= '0;
      din    <= '0;
    end else begin
      we <= w_sel && w_sel_rd != '0;
      if (w_sel && w_sel_rd != '0) begin
        rwaddr <= w_sel_rd;
        din    <= w_sel_data;
      end
    end
  end
  // destination registers still owed by buffered B entries
  always_comb begin
    pend_mask = '0;
    w_off     = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      w_off = AW'(i) - r_rp;
      if ({1'b0, w_off} < r_cnt) pend_mask[r_rd[i]] = 1'b1;
    end
    pend_mask[0] = 1'b0;
  end
endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameters: FIFO_DEPTH, default 4, number of B-result buffer entries (power of 2, min 2).
REQ-002 Parameters: STARVE_MAX, default 3, number of consecutive A-wins while B is pending before B is forced.
REQ-003 Clock and reset: one clock and a synchronous, active-high reset; ports are `clk` and `rst`.
REQ-004 Port list:
- `clk  in  1`  clock; all state updates on the rising edge.
- `rst  in  1`  synchronous, active-high reset.
- `a_valid  in  1`  single-cycle ALU/load result valid.
- `a_rd  in  5`  A destination register.
- `a_data  in  32`  A result.
- `a_ready  out  1`  A accepted this cycle (combinational).
- `b_valid  in  1`  mul/div result valid.
- `b_rd  in  5`  B destination register.
- `b_data  in  32`  B result.
- `b_ready  out  1`  B FIFO can accept (combinational).
- `we  out  1`  register-file write enable (registered).
- `rwaddr  out  5`  register-file write address (registered).
- `din  out  32`  register-file write data (registered).
- `pend_mask  out  32`  bit r=1 while any buffered B entry targets r, r!=0.

Function
REQ-005 The B path shall be a FIFO of FIFO_DEPTH entries {rd, data}; a B transfer shall occur when b_valid && b_ready, pushing at the tail.
REQ-006 b_ready shall equal (count < FIFO_DEPTH) and shall not depend on a same-cycle pop.
REQ-007 Only entries present at the start of a cycle shall be poppable; there is no bypass, so a B result is first visible on the write port 2 cycles after acceptance.
REQ-008 force shall equal (starve_cnt == STARVE_MAX) && (count != 0).
REQ-009 a_ready shall equal !force.
REQ-010 Each cycle, selection shall be:
- if force: pop the FIFO head to the write port;
- else if a_valid: take A;
- else if count != 0: pop the head;
- else: idle.
REQ-011 Output latency: the selected entry shall appear on we/rwaddr/din at the next rising edge (1 cycle).
REQ-012 we shall be 1 for exactly one cycle per selected entry with rd != 0.
REQ-013 An entry with rd == 0 shall be consumed normally (it pops, or asserts a_ready), but we shall be 0 for that cycle.
REQ-014 When idle, we shall be 0, and rwaddr/din shall hold their previous values.
REQ-015 starve_cnt:
- increments (saturating at STARVE_MAX) when A is selected while count != 0;
- clears on any FIFO pop, and whenever count == 0 at cycle start.
REQ-016 A simultaneous push and pop shall leave count unchanged; pointers shall wrap modulo FIFO_DEPTH; count width shall be log2(FIFO_DEPTH)+1.
REQ-017 FIFO order shall be preserved: B results are written in acceptance order.
REQ-018 pend_mask shall be combinational over the valid FIFO entries; bit 0 is always 0.
REQ-019 pend_mask shall clear an entry's bit in the same cycle that entry is popped (visible after the edge), and shall be set starting the cycle after the push.
REQ-020 A stalled A (a_valid && !a_ready) shall not change any state; upstream shall hold a_rd/a_data.

Reset
REQ-021 When rst=1 at a rising edge, the block shall clear count, the pointers and starve_cnt, and set we=0, rwaddr=0, din=0; pend_mask shall then read 0.
REQ-022 Reset shall take priority over any same-cycle push, pop or A selection, including mid-burst with the FIFO full; buffered entries shall be discarded.
REQ-023 In the reset cycle, b_ready and a_ready shall be don't-care, and no transfer shall be counted.

Verification
REQ-024 B only: a_valid=0; B push rd=5, data=0x1234 at cycle 0 → we=1, rwaddr=5, din=0x1234 at cycle 2; pend_mask[5]=1 at cycle 1 only.
REQ-025 Priority and starvation:
- stimulus: one B entry (rd=7) buffered, then a_valid=1 every cycle with rd=1..;
- response: 3 A writes, then a_ready=0 for one cycle and rd=7 is written, then A resumes.
REQ-026 Full FIFO:
- stimulus: a_valid=1 continuously with rd!=0, then 4 B pushes, then b_valid held high;
- response: b_ready=0 after the 4th push;
- response: a forced pop in the same cycle leaves b_ready=0 until the next edge;
- response: writes occur in push order.
REQ-027 x0 discard: A rd=0, data=0xDEAD, followed by B rd=0 → a_ready=1 and the FIFO pops, but we stays 0 throughout; pend_mask=0.
REQ-028 Reset mid-operation: 3 entries buffered, rst=1 for one cycle → we=0 and pend_mask=0 next cycle; subsequent B push rd=9 is written 2 cycles later, with no stale entries written.
REQ-029 Wrap-around: 10 B pushes interleaved with pops, data=i, rd=i+1 → 10 writes in order, count returns to 0, and no spurious we.
